// File: rtl/seq_rca_addsub_pkg.sv
// ============================================================================
// seq_rca_addsub_pkg : op encodings and FSM states for seq_rca_addsub
// Revision: 1.0
// ============================================================================
`default_nettype none

package seq_rca_addsub_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/seq_rca_addsub_rca_slice.sv
// ============================================================================
// rca_slice : CHUNK-bit ripple-carry adder built from full-adder cells
// Revision: 1.0
// ============================================================================
`default_nettype none

module fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

module rca_slice #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_c;

  assign w_c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    fa u_fa (
      .a  (a[i]),
      .b  (b[i]),
      .ci (w_c[i]),
      .s  (s[i]),
      .co (w_c[i+1])
    );
  end

  assign co       = w_c[CHUNK];
  // Carry into the top bit, paired with co to detect signed overflow.
  assign c_msb_in = w_c[CHUNK-1];

endmodule

`default_nettype wire

// File: rtl/seq_rca_addsub.sv
// ============================================================================
// seq_rca_addsub : multi-cycle ripple-carry adder/subtractor, CHUNK bits/clock
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_rca_addsub
  import seq_rca_addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] y,
  output logic             co,
  output logic             ovf
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic [WIDTH-1:0]   y_q, y_d;
  logic               co_q, co_d, ovf_q, ovf_d;
  logic               accept;

  logic [CHUNK-1:0]   w_sum;
  logic               w_sco, w_smsb;
  logic [WIDTH-1:0]   w_res_shift;

  rca_slice #(.CHUNK(CHUNK)) u_slice (
    .a        (a_q[CHUNK-1:0]),
    .b        (b_q[CHUNK-1:0]),
    .cin      (carry_q),
    .s        (w_sum),
    .co       (w_sco),
    .c_msb_in (w_smsb)
  );

  // New slice enters at the top so the LSB slice ends up at the bottom.
  if (NCHUNK == 1) begin : g_single
    assign w_res_shift = w_sum;
  end else begin : g_multi
    assign w_res_shift = {w_sum, res_q[WIDTH-1:CHUNK]};
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    k_d     = k_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    accept  = 1'b0;

    unique case (state_q)
      S_IDLE: accept = start;
      S_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        res_d   = w_res_shift;
        carry_d = w_sco;
        k_d     = k_q + CNT_W'(1);
        if (k_q == CNT_W'(NCHUNK - 1)) begin
          state_d = S_DONE;
          y_d     = w_res_shift;
          co_d    = w_sco;
          ovf_d   = w_smsb ^ w_sco;
        end
      end
      S_DONE: begin
        accept = start;
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      state_d = S_RUN;
      a_d     = a;
      k_d     = '0;
      if (op_sub == OP_SUB) begin
        b_d     = ~b;
        carry_d = 1'b1;
      end else begin
        b_d     = b;
        carry_d = cin;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign y    = y_q;
  assign co   = co_q;
  assign ovf  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_rca_addsub.sv
// ============================================================================
// tb_seq_rca_addsub : directed self-checking bench for seq_rca_addsub
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_seq_rca_addsub;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start, op_sub, cin;
  logic [31:0] a, b;
  logic        busy, done, co, ovf;
  logic [31:0] y;

  logic        start8, op8, cin8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, co8, ovf8;
  logic [7:0]  y8;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic [31:0] y;
    logic        co;
    logic        ovf;
  } vec_t;

  seq_rca_addsub #(.WIDTH(32), .CHUNK(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op_sub(op_sub),
    .a(a), .b(b), .cin(cin), .busy(busy), .done(done),
    .y(y), .co(co), .ovf(ovf)
  );

  seq_rca_addsub #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .reset_n(reset_n), .start(start8), .op_sub(op8),
    .a(a8), .b(b8), .cin(cin8), .busy(busy8), .done(done8),
    .y(y8), .co(co8), .ovf(ovf8)
  );

  always #5 clk = ~clk;

  // Issues one operation, scrambles the operand inputs after the accept edge,
  // then counts cycles (and busy cycles) until done or the bound expires.
  task automatic do_op(input logic op, input logic [31:0] av, input logic [31:0] bv,
                       input logic ci, output int lat, output int nb);
    @(negedge clk);
    start = 1'b1; op_sub = op; a = av; b = bv; cin = ci;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    cin = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
    lat = 0; nb = 0;
    while (!done && lat < 20) begin
      if (busy) nb++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    int lat, nb;
    logic seen;
    reset_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      start = 1'($urandom_range(0, 1)); op_sub = 1'($urandom_range(0, 1));
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    end
    #1;
    n_tests++;
    if ({busy, done, y, co, ovf} !== 35'd0) begin
      $display("FAIL reset_hold: busy=%b done=%b y=%h co=%b ovf=%b, want all 0", busy, done, y, co, ovf);
      n_fail++;
    end
    @(negedge clk);
    start = 1'b0;
    reset_n = 1'b1;

    do_op(1'b0, 32'hC000_0000, 32'h8000_0000, 1'b0, lat, nb);
    n_tests++;
    if ({y, co, ovf} !== {32'h4000_0000, 1'b1, 1'b1}) begin
      $display("FAIL pre_abort_op: y=%h co=%b ovf=%b, want 40000000 1 1", y, co, ovf);
      n_fail++;
    end

    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 32'h1; b = 32'h1; cin = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if ({busy, done, y, co, ovf} !== 35'd0) begin
      $display("FAIL reset_midrun: busy=%b done=%b y=%h co=%b ovf=%b, want all 0", busy, done, y, co, ovf);
      n_fail++;
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      $display("FAIL abort_no_done: activity seen=%b, want 0", seen);
      n_fail++;
    end
  endtask

  task automatic test_basic_add();
    int lat, nb;
    do_op(1'b0, 32'h1, 32'h1, 1'b0, lat, nb);
    n_tests++;
    if (lat !== 4 || nb !== 4) begin
      $display("FAIL basic_latency: lat=%0d busy_cycles=%0d, want 4 4", lat, nb);
      n_fail++;
    end
    n_tests++;
    if ({y, co, ovf} !== {32'h2, 1'b0, 1'b0}) begin
      $display("FAIL basic_result: y=%h co=%b ovf=%b, want 00000002 0 0", y, co, ovf);
      n_fail++;
    end
    @(posedge clk); #1;
    n_tests++;
    if (done !== 1'b0 || busy !== 1'b0 || y !== 32'h2) begin
      $display("FAIL done_pulse: done=%b busy=%b y=%h, want 0 0 00000002", done, busy, y);
      n_fail++;
    end
  endtask

  task automatic test_vectors();
    vec_t v[7];
    int lat, nb;
    v[0] = '{1'b0, 32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    v[1] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0};
    v[2] = '{1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    v[3] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1};
    v[4] = '{1'b1, 32'h0000_0005, 32'h0000_0003, 1'b1, 32'h0000_0002, 1'b1, 1'b0};
    v[5] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    v[6] = '{1'b1, 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      do_op(v[i].op, v[i].a, v[i].b, v[i].ci, lat, nb);
      n_tests++;
      if (lat !== 4 || {y, co, ovf} !== {v[i].y, v[i].co, v[i].ovf}) begin
        $display("FAIL vec%0d: lat=%0d y=%h co=%b ovf=%b, want 4 %h %b %b",
                 i, lat, y, co, ovf, v[i].y, v[i].co, v[i].ovf);
        n_fail++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat, lat2;
    @(negedge clk);
    start = 1'b1; op_sub = 1'b0; a = 32'd1; b = 32'd2; cin = 1'b0;
    @(posedge clk); #1;
    a = 32'd10; b = 32'd20;
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    n_tests++;
    if (lat !== 4 || y !== 32'd3) begin
      $display("FAIL b2b_first: lat=%0d y=%h, want 4 00000003", lat, y);
      n_fail++;
    end
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom;
    n_tests++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      $display("FAIL b2b_accept: busy=%b done=%b, want 1 0", busy, done);
      n_fail++;
    end
    lat2 = 0;
    while (!done && lat2 < 20) begin
      @(posedge clk); #1;
      lat2++;
    end
    n_tests++;
    if (lat2 + 1 !== 5 || y !== 32'd30) begin
      $display("FAIL b2b_second: spacing=%0d y=%h, want 5 0000001e", lat2 + 1, y);
      n_fail++;
    end
  endtask

  task automatic test_narrow();
    logic [7:0] av[2], bv[2], yv[2];
    logic       ov[2];
    int lat;
    av[0] = 8'h01; bv[0] = 8'h01; yv[0] = 8'h02; ov[0] = 1'b0;
    av[1] = 8'h7F; bv[1] = 8'h01; yv[1] = 8'h80; ov[1] = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      start8 = 1'b1; op8 = 1'b0; a8 = av[i]; b8 = bv[i]; cin8 = 1'b0;
      @(posedge clk); #1;
      start8 = 1'b0; a8 = 8'hA5; b8 = 8'h5A;
      lat = 0;
      while (!done8 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      n_tests++;
      if (lat !== 1 || y8 !== yv[i] || co8 !== 1'b0 || ovf8 !== ov[i]) begin
        $display("FAIL narrow%0d: lat=%0d y=%h co=%b ovf=%b, want 1 %h 0 %b",
                 i, lat, y8, co8, ovf8, yv[i], ov[i]);
        n_fail++;
      end
    end
  endtask

  initial begin
    start = 1'b0; op_sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    test_reset();
    test_basic_add();
    test_vectors();
    test_back_to_back();
    test_narrow();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
